// File: rtl/ddr_cke_lpbk_bist_ctrl_if.sv
// ddr_cke_lpbk_bist_ctrl_if: control, config, status and pad-driver signals of the CKE loopback BIST
interface ddr_cke_lpbk_bist_ctrl_if #(
  parameter int SETTLE_W = 4,
  parameter int ERR_W = 8
);
  logic i_start;
  logic i_abort;
  logic [SETTLE_W-1:0] i_cfg_settle;
  logic [7:0] i_cfg_num;
  logic [7:0] i_cfg_seed;
  logic i_d_lpbk;
  logic o_d_n;
  logic o_oe;
  logic o_hiz_n;
  logic o_lpbk_en;
  logic o_busy;
  logic o_done;
  logic o_pass;
  logic [ERR_W-1:0] o_err_cnt;
  logic [7:0] o_first_err_idx;
  modport master (
    output i_start, i_abort, i_cfg_settle, i_cfg_num, i_cfg_seed, i_d_lpbk,
    input o_d_n, o_oe, o_hiz_n, o_lpbk_en, o_busy, o_done, o_pass, o_err_cnt, o_first_err_idx
  );
  modport slave (
    input i_start, i_abort, i_cfg_settle, i_cfg_num, i_cfg_seed, i_d_lpbk,
    output o_d_n, o_oe, o_hiz_n, o_lpbk_en, o_busy, o_done, o_pass, o_err_cnt, o_first_err_idx
  );
endinterface

// File: rtl/ddr_cke_lpbk_bist_ctrl.sv
// ddr_cke_lpbk_bist_ctrl: drives an LFSR pattern onto the CKE pad and counts loopback mismatches
module ddr_cke_lpbk_bist_ctrl #(
  parameter int SETTLE_W = 4,
  parameter int ERR_W = 8
) (
  input logic i_clk,
  input logic i_rst_n,
  ddr_cke_lpbk_bist_ctrl_if.slave bus
);
  localparam int CW = SETTLE_W + 1;
  typedef enum logic [1:0] {IDLE, WARM, DRIVE, FIN} state_t;
  state_t state;
  logic [SETTLE_W-1:0] settle;
  logic [CW-1:0] cnt, reload;
  logic [7:0] num, lfsr, lfsr_n, k, first;
  logic [ERR_W-1:0] err, err_n;
  logic s1, s2, mism, d_n, oe, hiz_n, lpbk_en, busy, done, pass;
  always_comb begin
    lfsr_n = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    mism = s2 != lfsr[7];
    err_n = mism && !(&err) ? err + ERR_W'(1) : err;
    reload = CW'(settle) + CW'(2);
  end
  // each bit (and the warm-up) spans reload+1 cycles; the compare lands on the last one
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      settle <= '0;
      cnt <= '0;
      num <= '0;
      lfsr <= '0;
      k <= '0;
      first <= 8'hFF;
      err <= '0;
      {s1, s2} <= 2'b00;
      {d_n, oe, hiz_n, lpbk_en, busy, done, pass} <= 7'b1000000;
    end else begin
      s1 <= bus.i_d_lpbk;
      s2 <= s1;
      done <= 1'b0;
      case (state)
        IDLE: if (bus.i_start) begin
          settle <= bus.i_cfg_settle;
          num <= bus.i_cfg_num;
          lfsr <= bus.i_cfg_seed == 8'h00 ? 8'h01 : bus.i_cfg_seed;
          err <= '0;
          first <= 8'hFF;
          k <= '0;
          cnt <= CW'(bus.i_cfg_settle) + CW'(2);
          state <= bus.i_cfg_num == 8'd0 ? FIN : WARM;
          done <= bus.i_cfg_num == 8'd0;
          pass <= bus.i_cfg_num == 8'd0;
          {d_n, oe, hiz_n, lpbk_en, busy} <= bus.i_cfg_num == 8'd0 ? 5'b10000 : 5'b11111;
        end
        WARM, DRIVE: if (bus.i_abort) begin
          state <= IDLE;
          pass <= 1'b0;
          {d_n, oe, hiz_n, lpbk_en, busy} <= 5'b10000;
        end else if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end else if (state == WARM) begin
          state <= DRIVE;
          d_n <= ~lfsr[7];
          cnt <= reload;
        end else begin
          err <= err_n;
          first <= mism && first == 8'hFF ? k : first;
          lfsr <= lfsr_n;
          k <= k + 8'd1;
          cnt <= reload;
          if (k + 8'd1 == num) begin
            state <= FIN;
            done <= 1'b1;
            pass <= err_n == '0;
            {d_n, oe, hiz_n, lpbk_en, busy} <= 5'b10000;
          end else begin
            d_n <= ~lfsr_n[7];
          end
        end
        default: state <= IDLE;
      endcase
    end
  assign {bus.o_d_n, bus.o_oe, bus.o_hiz_n, bus.o_lpbk_en, bus.o_busy, bus.o_done, bus.o_pass} =
    {d_n, oe, hiz_n, lpbk_en, busy, done, pass};
  assign bus.o_err_cnt = err;
  assign bus.o_first_err_idx = first;
endmodule

// File: tb/tb_ddr_cke_lpbk_bist_ctrl.sv
// tb_ddr_cke_lpbk_bist_ctrl: timeline model of the BIST run checked every cycle against an 8-bit and a 4-bit counter build
module tb_ddr_cke_lpbk_bist_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [3:0] settle = '0;
  logic [7:0] num = '0, seed = '0;
  int mode = 0;
  logic q8, q4;
  int n_chk = 0, n_fail = 0, n_done = 0;
  always #5 clk = ~clk;
  ddr_cke_lpbk_bist_ctrl_if #(.SETTLE_W(4), .ERR_W(8)) b8 ();
  ddr_cke_lpbk_bist_ctrl_if #(.SETTLE_W(4), .ERR_W(4)) b4 ();
  ddr_cke_lpbk_bist_ctrl #(.SETTLE_W(4), .ERR_W(8)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(b8));
  ddr_cke_lpbk_bist_ctrl #(.SETTLE_W(4), .ERR_W(4)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(b4));
  // loopback modes: 0 = ideal pad return one cycle late, 1 = stuck at 0, 2 = inverted pad
  always @(posedge clk) begin
    q8 <= ~b8.o_d_n;
    q4 <= ~b4.o_d_n;
  end
  assign {b8.i_start, b8.i_abort, b8.i_cfg_settle, b8.i_cfg_num, b8.i_cfg_seed} = {start, abort, settle, num, seed};
  assign {b4.i_start, b4.i_abort, b4.i_cfg_settle, b4.i_cfg_num, b4.i_cfg_seed} = {start, abort, settle, num, seed};
  assign b8.i_d_lpbk = mode == 0 ? q8 : mode == 1 ? 1'b0 : b8.o_d_n;
  assign b4.i_d_lpbk = mode == 0 ? q4 : mode == 1 ? 1'b0 : b4.o_d_n;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // model: m_t counts cycles since the accepted start (0 = idle)
  int m_t = 0, m_N = 0, m_L = 3, m_T = 1, m_mode = 0;
  int m_err8 = 0, m_err4 = 0, m_first = 255;
  bit m_pass = 0;
  bit m_bits[256];
  task automatic tally(input int nb, output int e8, output int e4, output int f);
    e8 = 0;
    e4 = 0;
    f = 255;
    for (int i = 0; i < nb; i++)
      if (m_mode == 2 || (m_mode == 1 && m_bits[i])) begin
        if (e8 < 255) e8++;
        if (e4 < 15) e4++;
        if (f == 255) f = i;
      end
  endtask
  always @(posedge clk or negedge rst_n) begin
    logic [7:0] l;
    int nb;
    if (!rst_n) begin
      m_t = 0;
      m_err8 = 0;
      m_err4 = 0;
      m_first = 255;
      m_pass = 0;
    end else if (m_t != 0) begin
      if (m_N != 0 && m_t <= (m_N + 1) * m_L && abort) begin
        nb = (m_t - 1) / m_L - 1;
        tally(nb < 0 ? 0 : nb, m_err8, m_err4, m_first);
        m_pass = 0;
        m_t = 0;
      end else if (m_t == m_T) m_t = 0;
      else m_t++;
    end else if (start) begin
      m_N = int'(num);
      m_L = int'(settle) + 3;
      m_T = m_N == 0 ? 1 : (m_N + 1) * m_L + 1;
      m_mode = mode;
      l = seed == 8'h00 ? 8'h01 : seed;
      for (int i = 0; i < m_N; i++) begin
        m_bits[i] = l[7];
        l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
      tally(m_N, m_err8, m_err4, m_first);
      m_pass = m_err8 == 0;
      m_t = 1;
    end
  end
  always @(negedge clk) begin
    logic [5:0] e;
    bit in_run, fin;
    in_run = m_N != 0 && m_t >= 1 && m_t <= (m_N + 1) * m_L;
    fin = m_t != 0 && m_t == m_T;
    e = in_run ? {m_t <= m_L ? 1'b1 : ~m_bits[(m_t - 1) / m_L - 1], 5'b11110} : fin ? 6'b100001 : 6'b100000;
    chk("ctl8", {b8.o_d_n, b8.o_oe, b8.o_hiz_n, b8.o_lpbk_en, b8.o_busy, b8.o_done}, e);
    chk("ctl4", {b4.o_d_n, b4.o_oe, b4.o_hiz_n, b4.o_lpbk_en, b4.o_busy, b4.o_done}, e);
    if (in_run) begin
      chk("pass8 run", b8.o_pass, 0);
      chk("pass4 run", b4.o_pass, 0);
    end else begin
      chk("err8", b8.o_err_cnt, m_err8);
      chk("err4", b4.o_err_cnt, m_err4);
      chk("first8", b8.o_first_err_idx, m_first);
      chk("first4", b4.o_first_err_idx, m_first);
      chk("pass8", b8.o_pass, m_pass);
      chk("pass4", b4.o_pass, m_pass);
    end
    if (b8.o_done) n_done++;
  end
  task automatic run(input int s, input int n, input int sd, input int md, output int lat);
    @(negedge clk);
    settle = 4'(s);
    num = 8'(n);
    seed = 8'(sd);
    mode = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    settle = ~settle;
    num = ~num;
    seed = ~seed;
    lat = 1;
    while (!b8.o_done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    int lat, snap;
    repeat (3) @(negedge clk);
    chk("rst first", b8.o_first_err_idx, 8'hFF);
    chk("rst err", b8.o_err_cnt, 0);
    chk("rst d_n", b8.o_d_n, 1);
    rst_n = 1'b1;
    run(2, 16, 8'hA5, 0, lat);
    chk("ideal latency", lat, 86);
    chk("ideal pass", b8.o_pass, 1);
    chk("ideal err", b8.o_err_cnt, 0);
    chk("ideal first", b8.o_first_err_idx, 8'hFF);
    run(1, 8, 8'h80, 1, lat);
    chk("stuck latency", lat, 37);
    chk("stuck err", b8.o_err_cnt, 1);
    chk("stuck first", b8.o_first_err_idx, 0);
    chk("stuck pass", b8.o_pass, 0);
    run(0, 8, 8'h00, 1, lat);
    chk("seed0 latency", lat, 28);
    chk("seed0 err", b8.o_err_cnt, 1);
    chk("seed0 first", b8.o_first_err_idx, 7);
    run(1, 32, 8'h3C, 2, lat);
    chk("inv latency", lat, 133);
    chk("inv err8", b8.o_err_cnt, 32);
    chk("inv err4 sat", b4.o_err_cnt, 15);
    chk("inv first", b4.o_first_err_idx, 0);
    run(3, 0, 8'h11, 0, lat);
    chk("n0 latency", lat, 1);
    chk("n0 pass", b8.o_pass, 1);
    chk("n0 err", b8.o_err_cnt, 0);
    chk("n0 oe", b8.o_oe, 0);
    @(negedge clk);
    {settle, num, seed, mode} = {4'd1, 8'd8, 8'h80, 1};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    abort = 1'b1;
    #1 snap = n_done;
    @(negedge clk);
    abort = 1'b0;
    chk("abort ctl", {b8.o_oe, b8.o_hiz_n, b8.o_lpbk_en, b8.o_busy}, 0);
    chk("abort err", b8.o_err_cnt, 1);
    chk("abort pass", b8.o_pass, 0);
    repeat (40) @(negedge clk);
    #1 chk("abort no done", n_done - snap, 0);
    @(negedge clk);
    {settle, num, seed, mode} = {4'd2, 8'd16, 8'hA5, 1};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    chk("pre-reset busy", b8.o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ctl", {b8.o_d_n, b8.o_oe, b8.o_hiz_n, b8.o_lpbk_en, b8.o_busy}, 5'b10000);
    chk("async rst err", b8.o_err_cnt, 0);
    chk("async rst first", b8.o_first_err_idx, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    #1 snap = n_done;
    @(negedge clk);
    {settle, num, seed, mode} = {4'd0, 8'd4, 8'h33, 2};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    #1 chk("one done per start", n_done - snap, 1);
    snap = n_done;
    @(negedge clk);
    {settle, num, seed, mode} = {4'd0, 8'd0, 8'h01, 0};
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("retrigger dones", n_done - snap, 3);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
